// File: rtl/hls_saturation_enmul_pipe.sv
// Pipelined unsigned multiplier with right shift and saturation to OUT_W bits.
// Optional round-half-up on the shift: define HLS_SAT_ENMUL_ROUND_EN.
module hls_saturation_enmul_pipe #(
  parameter int A_W       = 19,
  parameter int B_W       = 8,
  parameter int OUT_W     = 27,
  parameter int SHIFT     = 0,
  parameter int NUM_STAGE = 3
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic             sat_flag,
  input  logic             sat_clr,
  output logic [15:0]      sat_count
);

  localparam int PW = A_W + B_W;

  logic             ce;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_pipe [1:NUM_STAGE-1];
  logic [NUM_STAGE:1] valid_pipe;
  logic [PW:0]      s_full;
  logic             sat;
  logic [OUT_W-1:0] dout_reg;
  logic             sat_reg;
  logic [15:0]      sat_count_reg;

  // One enable for the whole pipe: it only stalls when the output slot is full.
  assign ce        = !out_valid || out_ready;
  assign in_ready  = ce;
  assign out_valid = valid_pipe[NUM_STAGE];
  assign prod      = PW'(din0) * PW'(din1);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      valid_pipe <= '0;
    end else if (ce) begin
      valid_pipe <= {valid_pipe[NUM_STAGE-1:1], in_valid};
    end
  end

  // Product stages carry no reset; their contents only matter when valid.
  always_ff @(posedge ap_clk) begin
    if (ce) begin
      prod_pipe[1] <= prod;
      for (int i = 2; i < NUM_STAGE; i++) begin
        prod_pipe[i] <= prod_pipe[i-1];
      end
    end
  end

  generate
`ifdef HLS_SAT_ENMUL_ROUND_EN
    if (SHIFT > 0) begin : g_round
      localparam logic [PW:0] HALF = (PW+1)'(1) << (SHIFT - 1);
      assign s_full = ({1'b0, prod_pipe[NUM_STAGE-1]} + HALF) >> SHIFT;
    end else begin : g_trunc
      assign s_full = {1'b0, prod_pipe[NUM_STAGE-1] >> SHIFT};
    end
`else
    if (1) begin : g_trunc
      assign s_full = {1'b0, prod_pipe[NUM_STAGE-1] >> SHIFT};
    end
`endif
  endgenerate

  assign sat = |s_full[PW:OUT_W];

  // Output register loads only with a valid result so dout stays 0 after reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout_reg <= '0;
      sat_reg  <= 1'b0;
    end else if (ce && valid_pipe[NUM_STAGE-1]) begin
      dout_reg <= sat ? {OUT_W{1'b1}} : s_full[OUT_W-1:0];
      sat_reg  <= sat;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst || sat_clr) begin
      sat_count_reg <= '0;
    end else if (out_valid && out_ready && sat_reg && (sat_count_reg != 16'hFFFF)) begin
      sat_count_reg <= sat_count_reg + 16'd1;
    end
  end

  assign dout      = dout_reg;
  assign sat_flag  = sat_reg;
  assign sat_count = sat_count_reg;

endmodule

// File: doc/hls_saturation_enmul_pipe.md
HLS_SATURATION_ENMUL_PIPE -- requirements
Module: hls_saturation_enmul_pipe

Interface
REQ-001 SHALL have parameter A_W, default 19: unsigned width of operand a.
REQ-002 SHALL have parameter B_W, default 8: unsigned width of operand b.
REQ-003 SHALL have parameter OUT_W, default 27: width of the result; legal range 1..A_W+B_W.
REQ-004 SHALL have parameter SHIFT, default 0: right shift applied to the product; legal range 0..A_W+B_W-1.
REQ-005 SHALL have parameter NUM_STAGE, default 3: pipeline latency in clocks; legal range 2..6.
REQ-006 SHALL have port ap_clk  in  1  sole clock; all logic on the rising edge.
REQ-007 SHALL have port ap_rst  in  1  reset, synchronous and active-high.
REQ-008 SHALL have port in_valid  in  1  operand pair present.
REQ-009 SHALL have port in_ready  out  1  block accepts operands this cycle.
REQ-010 SHALL have port din0  in  A_W  operand a, unsigned.
REQ-011 SHALL have port din1  in  B_W  operand b, unsigned.
REQ-012 SHALL have port out_valid  out  1  result present.
REQ-013 SHALL have port out_ready  in  1  downstream accepts the result.
REQ-014 SHALL have port dout  out  OUT_W  result after shift and saturation.
REQ-015 SHALL have port sat_flag  out  1  the current dout was clamped; qualified by out_valid.
REQ-016 SHALL have port sat_clr  in  1  clears sat_count.
REQ-017 SHALL have port sat_count  out  16  count of saturated results delivered.

Function
REQ-018 SHALL form the full product P = din0*din1 at width A_W+B_W, unsigned, with no truncation.
REQ-019 SHALL compute S = P >> SHIFT (logical shift).
REQ-020 If S > 2^OUT_W-1, SHALL drive dout to all ones and sat_flag to 1; otherwise dout = S[OUT_W-1:0] and sat_flag = 0.
REQ-021 SHALL accept an operand pair on any rising edge where in_valid and in_ready are both 1.
REQ-022 SHALL deliver a result on any rising edge where out_valid and out_ready are both 1.
REQ-023 SHALL use a global pipeline enable ce = !out_valid || out_ready; in_ready SHALL equal ce, combinationally.
REQ-024 When ce = 0, SHALL hold every stage register, including the valid bits, unchanged.
REQ-025 With ce held at 1, out_valid SHALL rise NUM_STAGE rising edges after the accepting edge, counting the accepting edge as the first.
REQ-026 SHALL support back-to-back throughput of one result per clock with no bubbles inserted.
REQ-027 SHALL preserve order, with no loss or duplication of operand pairs under any out_ready pattern.
REQ-028 Each stage SHALL carry a valid bit; data registers MAY load freely while their valid bit is 0.
REQ-029 On a delivery (REQ-022) with sat_flag = 1, sat_count SHALL increment by 1 and SHALL stick at 0xFFFF with no wrap.
REQ-030 When sat_clr = 1, sat_count SHALL go to 0 on the next edge; this wins over a simultaneous increment.
REQ-031 sat_count SHALL change only on deliveries; a stalled saturated result SHALL be counted exactly once.

Reset
REQ-032 On an edge with ap_rst = 1: all stage valid bits SHALL clear to 0, out_valid SHALL be 0, and sat_count SHALL be 0.
REQ-033 While ap_rst = 1, in_ready SHALL read 1 (ce = 1 because out_valid = 0); operands presented during reset SHALL be discarded.
REQ-034 dout and sat_flag SHALL be 0 after reset, until the first valid result.
REQ-035 A reset during a stream SHALL drop all in-flight results with no partial output.

Configuration
REQ-036 With macro HLS_SAT_ENMUL_ROUND_EN defined and SHIFT > 0, SHALL compute S = (P + 2^(SHIFT-1)) >> SHIFT, round-half-up, at width A_W+B_W+1 so the add cannot overflow.
REQ-037 Without the macro, or with SHIFT = 0, SHALL use truncation per REQ-019 and instantiate no rounding adder.

Verification
REQ-038 Defaults; din0=0x7FFFF, din1=0xFF, out_ready=1 -> dout=0x7F7FF01, sat_flag=0, out_valid on the 3rd edge.
REQ-039 OUT_W=16; din0=300, din1=255 -> dout=0xFFFF, sat_flag=1, sat_count=1 after delivery.
REQ-040 Stream 8 pairs (a=1..8, b=2) with out_ready low for cycles 3-7 -> in_ready low during the stall; outputs 2,4,...,16 in order, each exactly once.
REQ-041 Assert ap_rst for 1 cycle with 2 results in flight -> out_valid=0 and sat_count=0 next cycle; no stale output afterwards.
REQ-042 SHIFT=4; din0=24, din1=1 -> dout=1 without the macro, dout=2 with HLS_SAT_ENMUL_ROUND_EN.
REQ-043 sat_count=5; sat_clr=1 on the same edge as a saturated delivery -> sat_count=0; a saturated result held 4 stalled cycles -> sat_count increments once.
